trigger_capture: RTL

- Downstream consumer of the ADC threshold trigger stage; sits between the trigger and the UART transmitter.
- Continuously records the 14-bit ADC stream into a circular buffer. On a trigger it freezes a window of PRE samples before the trigger and DEPTH-PRE samples from the trigger onward.
- It then streams the window out as bytes over a valid/ready handshake to the UART TX.
- Software re-arms it with a one-cycle arm pulse.

---
 rtl/trigger_capture.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/trigger_capture.sv
// Pre/post trigger capture: records the ADC stream into a circular buffer, freezes a
// window around the trigger and streams it out as bytes over a valid/ready handshake.
module trigger_capture #(
    parameter int          DEPTH  = 256,
    parameter int          AW     = 8,
    parameter int          PRE    = 64,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] ADC_IN,
    input  logic        trigger,
    input  logic        arm,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DUMP
    } state_t;

    // Which byte of the current sample goes out next; P_END waits for the final accept.
    typedef enum logic [1:0] {
        P_HI,
        P_LO,
        P_END
    } phase_t;

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE - 1);
    localparam logic [AW:0]   REC_LEN   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   REC_ONE   = (AW + 1)'(1);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [13:0]   adc_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [AW-1:0] trig_ptr_q, trig_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   samp_cnt_q, samp_cnt_d;
    logic          data_ok_q, data_ok_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          done_q, done_d;
    logic          wr_en;
    logic          slot_free;
    logic [13:0]   rd_data_q;
    logic [13:0]   mem [DEPTH];

    // Output register may be reloaded when empty or when its byte is taken this cycle.
    assign slot_free = !tx_valid_q || tx_ready;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        post_cnt_d = post_cnt_q;
        trig_ptr_d = trig_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        samp_cnt_d = samp_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                end
            end
            S_FILL: begin
                wr_en      = 1'b1;
                fill_cnt_d = fill_cnt_q + ONE;
                if (fill_cnt_q == PRE_LAST) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en = 1'b1;
                if (trigger) begin
                    trig_ptr_d = wr_ptr_q;
                    post_cnt_d = POST_INIT;
                    state_d    = S_POST;
                end
            end
            S_POST: begin
                wr_en      = 1'b1;
                post_cnt_d = post_cnt_q - ONE;
                if (post_cnt_q == ONE) begin
                    state_d    = S_DUMP;
                    rd_ptr_d   = trig_ptr_q - PRE_OFS;
                    samp_cnt_d = REC_LEN;
                    phase_d    = P_HI;
                    tx_data_d  = HEADER;
                    tx_valid_d = 1'b1;
                end
            end
            S_DUMP: begin
                if (slot_free) begin
                    unique case (phase_q)
                        P_HI: begin
                            // A fresh read address needs one cycle before its data is usable.
                            if (data_ok_q) begin
                                tx_data_d  = {2'b00, rd_data_q[13:8]};
                                tx_valid_d = 1'b1;
                                phase_d    = P_LO;
                            end else begin
                                tx_valid_d = 1'b0;
                            end
                        end
                        P_LO: begin
                            tx_data_d  = rd_data_q[7:0];
                            tx_valid_d = 1'b1;
                            rd_ptr_d   = rd_ptr_q + ONE;
                            samp_cnt_d = samp_cnt_q - REC_ONE;
                            phase_d    = (samp_cnt_q == REC_ONE) ? P_END : P_HI;
                        end
                        P_END: begin
                            tx_valid_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = S_IDLE;
                        end
                        default: phase_d = P_HI;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
    end

    // rd_data_q always reflects the address held on the previous cycle.
    assign data_ok_d = (state_q == S_DUMP) && (rd_ptr_d == rd_ptr_q);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= P_HI;
            adc_q      <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            post_cnt_q <= '0;
            trig_ptr_q <= '0;
            rd_ptr_q   <= '0;
            samp_cnt_q <= '0;
            data_ok_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            adc_q      <= ADC_IN;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            post_cnt_q <= post_cnt_d;
            trig_ptr_q <= trig_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            samp_cnt_q <= samp_cnt_d;
            data_ok_q  <= data_ok_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the sample RAM is deliberately left out of reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= adc_q;
        end
        rd_data_q <= mem[rd_ptr_q];
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
